// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - one 32-bit S-box lane shared between SubBytes state jobs and SubWord key words
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iStValid/oStReady     state job handshake, iState[0:127] (column c = iState[32c:32c+31])
//   oState, oStDone       SubBytes result and its one-cycle update pulse
//   iKwValid/oKwReady     key word handshake, iWord[0:31]
//   oWord, oKwDone        SubWord result and its one-cycle update pulse
//   oBusy                 state job in progress
//   oStallCnt             (SBOX_SHARE_STATS_EN only) RUN cycles whose slot went to the key
// Parameter KW_PRIORITY: 0 = alternate state/key on contention, 1 = key always wins.

module s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX_TABLE[in_byte];
endmodule

module sbox_share_ctrl #(
  parameter int KW_PRIORITY = 0
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStValid,
  output logic         oStReady,
  input  logic [0:127] iState,
  output logic [0:127] oState,
  output logic         oStDone,
  input  logic         iKwValid,
  output logic         oKwReady,
  input  logic [0:31]  iWord,
  output logic [0:31]  oWord,
  output logic         oKwDone,
  output logic         oBusy
`ifdef SBOX_SHARE_STATS_EN
  ,
  output logic [15:0]  oStallCnt
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [0:127] work_q, work_d;
  logic [0:127] ost_q, ost_d;
  logic [0:31]  oword_q, oword_d;
  logic         st_done_q, st_done_d;
  logic         kw_done_q, kw_done_d;
  logic         last_kw_q, last_kw_d;   // 1: last used slot went to the key

  logic         run;
  logic         st_accept;
  logic         kw_fire;
  logic         col_fire;
  logic [0:31]  lane_in;
  logic [0:31]  lane_out;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    s_box u_s_box (
      .in_byte  (lane_in[8*i +: 8]),
      .out_byte (lane_out[8*i +: 8])
    );
  end

  always_comb begin
    run       = (state_q == ST_RUN);
    oStReady  = !iRst && !run;
    if (iRst) begin
      oKwReady = 1'b0;
    end else if (!run || (KW_PRIORITY != 0)) begin
      oKwReady = 1'b1;
    end else begin
      // Round-robin: the key only gets the slot after a column pass.
      oKwReady = !last_kw_q;
    end
    st_accept = iStValid && oStReady;
    kw_fire   = iKwValid && oKwReady;
    // A ready-but-idle key port does not waste the slot.
    col_fire  = run && !kw_fire;
    lane_in   = kw_fire ? iWord : work_q[{col_q, 5'd0} +: 32];

    state_d   = state_q;
    col_d     = col_q;
    work_d    = work_q;
    ost_d     = ost_q;
    oword_d   = oword_q;
    st_done_d = 1'b0;
    kw_done_d = kw_fire;
    last_kw_d = last_kw_q;

    if (kw_fire) begin
      oword_d   = lane_out;
      last_kw_d = 1'b1;
    end

    if (st_accept) begin
      work_d  = iState;
      col_d   = 2'd0;
      state_d = ST_RUN;
    end else if (col_fire) begin
      work_d[{col_q, 5'd0} +: 32] = lane_out;
      col_d     = 2'(col_q + 2'd1);
      last_kw_d = 1'b0;
      if (col_q == 2'd3) begin
        // Publish the whole buffer at once so oState never shows a mix of old and new.
        ost_d     = work_d;
        st_done_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      col_q     <= 2'd0;
      work_q    <= '0;
      ost_q     <= '0;
      oword_q   <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      last_kw_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      work_q    <= work_d;
      ost_q     <= ost_d;
      oword_q   <= oword_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
      last_kw_q <= last_kw_d;
    end
  end

  assign oState  = ost_q;
  assign oStDone = st_done_q;
  assign oWord   = oword_q;
  assign oKwDone = kw_done_q;
  assign oBusy   = run;

`ifdef SBOX_SHARE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (st_accept) begin
      stall_cnt_d = 16'd0;
    end else if (run && kw_fire && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oStallCnt = stall_cnt_q;
`endif

endmodule
